// File: rtl/frankie_checkpoint_monitor.sv
// -----------------------------------------------------------------------------
// frankie_checkpoint_monitor
//
// Self-check unit placed beside the Frankie core on the FPGA. It watches NCHAN
// probed core registers. At programmed cycle counts after start, it compares
// them against expected values. It reports pass/fail plus diagnostics for the
// first failure, so program checks can run on hardware without a simulator.
//
// Optional feature macro: FRANKIE_MON_CONTINUE_EN
//   undefined : the first failing checkpoint ends the run.
//   defined   : mismatches are counted and the run continues through all
//               entries. fail is raised only when the run finishes.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   async active-high; clears all state and the table
//   start       in   pulse, begins a run (honoured in IDLE/DONE)
//   probe       in   NCHAN*WIDTH live register values; channel c = [c*WIDTH +: WIDTH]
//   cfg_we      in   table write strobe (honoured in IDLE/DONE)
//   cfg_idx     in   table entry written
//   cfg_cycle   in   cycle at which the entry fires
//   cfg_mask    in   channels compared (0 = entry always passes)
//   cfg_expect  in   expected channel values
//   cfg_num     in   number of active entries, latched on start
//   busy        out  run in progress
//   done        out  run finished (sticky until start/reset)
//   pass        out  done with no failure
//   fail        out  done with mismatch, missed checkpoint or timeout
//   fail_idx    out  entry of first failure
//   fail_chan   out  mismatching channels of first failure, all-ones = timeout
//   fail_value  out  probe value of lowest mismatching channel at first failure
//   chk_count   out  entries evaluated so far
//   err_count   out  failing entries, saturating at 255
// -----------------------------------------------------------------------------
module frankie_checkpoint_monitor #(
  parameter int WIDTH = 16,
  parameter int NCHAN = 4,
  parameter int NCHK  = 8,
  parameter int CNT_W = 16,
  parameter int IDX_W = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NCHAN*WIDTH-1:0] probe,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [CNT_W-1:0]       cfg_cycle,
  input  logic [NCHAN-1:0]       cfg_mask,
  input  logic [NCHAN*WIDTH-1:0] cfg_expect,
  input  logic [IDX_W:0]         cfg_num,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic [IDX_W-1:0]       fail_idx,
  output logic [NCHAN-1:0]       fail_chan,
  output logic [WIDTH-1:0]       fail_value,
  output logic [IDX_W:0]         chk_count,
  output logic [7:0]             err_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W:0] LP_NCHK = (IDX_W+1)'(NCHK);

  // Control and result registers
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cyc;
  logic [IDX_W:0]   r_n;
  logic [IDX_W:0]   r_chk_count;
  logic [7:0]       r_err_count;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;
  logic [IDX_W-1:0] r_fail_idx;
  logic [NCHAN-1:0] r_fail_chan;
  logic [WIDTH-1:0] r_fail_value;
  logic             r_have_fail;  // first-failure fields already captured

  // Checkpoint table
  logic [CNT_W-1:0]       r_tab_cycle  [NCHK];
  logic [NCHAN-1:0]       r_tab_mask   [NCHK];
  logic [NCHAN*WIDTH-1:0] r_tab_expect [NCHK];

  // Evaluation of the current entry
  logic [IDX_W-1:0] w_k;
  logic [CNT_W-1:0] w_cycle_k;
  logic             w_idle_like;
  logic             w_all_evald;
  logic             w_timeout;
  logic             w_fire;
  logic             w_missed;
  logic             w_eval;
  logic [NCHAN-1:0] w_diff;
  logic [WIDTH-1:0] w_low_val;
  logic             w_bad;
  logic [NCHAN-1:0] w_bad_chan;
  logic [WIDTH-1:0] w_bad_val;
  logic [IDX_W:0]   w_chk_next;
  logic             w_last;
  logic [7:0]       w_err_next;
  logic [IDX_W:0]   w_n_clamped;

  assign w_k         = r_chk_count[IDX_W-1:0];
  assign w_cycle_k   = r_tab_cycle[w_k];
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_all_evald = (r_chk_count == r_n);
  assign w_timeout   = (r_cyc == {CNT_W{1'b1}});
  assign w_fire      = (r_cyc == w_cycle_k);
  // A later cycle than the entry's slot means the table was not strictly
  // increasing and the slot has already gone by.
  assign w_missed    = (r_cyc > w_cycle_k);
  assign w_eval      = (r_state == ST_RUN) && !w_all_evald && !w_timeout && (w_fire || w_missed);
  assign w_bad       = w_missed || (|w_diff);
  assign w_bad_chan  = w_missed ? '0 : w_diff;
  assign w_bad_val   = w_missed ? '0 : w_low_val;
  assign w_chk_next  = r_chk_count + (IDX_W+1)'(1);
  assign w_last      = (w_chk_next == r_n);
  assign w_err_next  = (w_bad && (r_err_count != 8'hFF)) ? r_err_count + 8'd1 : r_err_count;
  assign w_n_clamped = (cfg_num > LP_NCHK) ? LP_NCHK : cfg_num;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_diff    = '0;
    w_low_val = '0;
    for (int c = 0; c < NCHAN; c++) begin
      w_diff[c] = r_tab_mask[w_k][c] &&
                  (probe[c*WIDTH +: WIDTH] != r_tab_expect[w_k][c*WIDTH +: WIDTH]);
    end
    // Walk downwards so the lowest mismatching channel is the one that sticks.
    for (int c = NCHAN-1; c >= 0; c--) begin
      if (w_diff[c]) w_low_val = probe[c*WIDTH +: WIDTH];
    end
  end

  // NOTE: the table is deliberately reset. A reset must leave it all-zero, and
  // it is small enough to live in flops rather than block RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCHK; i++) begin
        r_tab_cycle[i]  <= '0;
        r_tab_mask[i]   <= '0;
        r_tab_expect[i] <= '0;
      end
    end else if (cfg_we && w_idle_like) begin
      r_tab_cycle[cfg_idx]  <= cfg_cycle;
      r_tab_mask[cfg_idx]   <= cfg_mask;
      r_tab_expect[cfg_idx] <= cfg_expect;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cyc        <= '0;
      r_n          <= '0;
      r_chk_count  <= '0;
      r_err_count  <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_idx   <= '0;
      r_fail_chan  <= '0;
      r_fail_value <= '0;
      r_have_fail  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state      <= ST_RUN;
            r_cyc        <= '0;
            r_n          <= w_n_clamped;
            r_chk_count  <= '0;
            r_err_count  <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_idx   <= '0;
            r_fail_chan  <= '0;
            r_fail_value <= '0;
            r_have_fail  <= 1'b0;
          end
        end

        ST_RUN: begin
          r_cyc <= r_cyc + CNT_W'(1);
          if (w_all_evald) begin
            // Only reachable directly for a zero-length run.
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_pass  <= (r_err_count == 8'd0);
            r_fail  <= (r_err_count != 8'd0);
          end else if (w_timeout) begin
            // The counter's last value closes the run. An entry scheduled
            // there is treated as unreachable.
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_pass  <= 1'b0;
            r_fail  <= 1'b1;
            if (!r_have_fail) begin
              r_have_fail  <= 1'b1;
              r_fail_idx   <= w_k;
              r_fail_chan  <= '1;
              r_fail_value <= '0;
            end
          end else if (w_eval) begin
            r_chk_count <= w_chk_next;
            r_err_count <= w_err_next;
            if (w_bad && !r_have_fail) begin
              r_have_fail  <= 1'b1;
              r_fail_idx   <= w_k;
              r_fail_chan  <= w_bad_chan;
              r_fail_value <= w_bad_val;
            end
`ifdef FRANKIE_MON_CONTINUE_EN
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == 8'd0);
              r_fail  <= (w_err_next != 8'd0);
            end
`else
            if (w_bad || w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_pass  <= !w_bad;
              r_fail  <= w_bad;
            end
`endif
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (r_state == ST_RUN);
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign fail_idx   = r_fail_idx;
  assign fail_chan  = r_fail_chan;
  assign fail_value = r_fail_value;
  assign chk_count  = r_chk_count;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_frankie_checkpoint_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for frankie_checkpoint_monitor (CNT_W=4 so the timeout is reachable).
// Stimulus pushes the expected run result when it issues start. A monitor
// process pops and compares each time done rises, including the run latency
// counted in clock edges from the start edge.
// -----------------------------------------------------------------------------
module tb_frankie_checkpoint_monitor;

  localparam int WIDTH = 16;
  localparam int NCHAN = 4;
  localparam int NCHK  = 8;
  localparam int CNT_W = 4;
  localparam int IDX_W = 3;

  logic                   clock;
  logic                   reset;
  logic                   start;
  logic [NCHAN*WIDTH-1:0] probe;
  logic                   cfg_we;
  logic [IDX_W-1:0]       cfg_idx;
  logic [CNT_W-1:0]       cfg_cycle;
  logic [NCHAN-1:0]       cfg_mask;
  logic [NCHAN*WIDTH-1:0] cfg_expect;
  logic [IDX_W:0]         cfg_num;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic                   fail;
  logic [IDX_W-1:0]       fail_idx;
  logic [NCHAN-1:0]       fail_chan;
  logic [WIDTH-1:0]       fail_value;
  logic [IDX_W:0]         chk_count;
  logic [7:0]             err_count;

  frankie_checkpoint_monitor #(
    .WIDTH(WIDTH), .NCHAN(NCHAN), .NCHK(NCHK), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .probe(probe),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_cycle(cfg_cycle),
    .cfg_mask(cfg_mask), .cfg_expect(cfg_expect), .cfg_num(cfg_num),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_idx(fail_idx), .fail_chan(fail_chan), .fail_value(fail_value),
    .chk_count(chk_count), .err_count(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        pass;
    logic        fail;
    logic [2:0]  idx;
    logic [3:0]  chan;
    logic [15:0] val;
    logic [3:0]  chk;
    logic [7:0]  err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_no = 0;
  int          start_edge = 0;
  logic [63:0] prog [16];

  always @(posedge clock) edge_no <= edge_no + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Channel order: 0 mary, 1 shelley, 2 ra, 3 sp
  function automatic logic [63:0] pk(input logic [15:0] m, input logic [15:0] s,
                                     input logic [15:0] r, input logic [15:0] p);
    return {p, r, s, m};
  endfunction

  function automatic exp_t mk(input string name, input logic p, input logic f,
                              input logic [2:0] idx, input logic [3:0] chan,
                              input logic [15:0] val, input logic [3:0] chk,
                              input logic [7:0] err, input int lat);
    exp_t e;
    e.name = name; e.pass = p; e.fail = f; e.idx = idx; e.chan = chan;
    e.val = val; e.chk = chk; e.err = err; e.lat = lat;
    return e;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_wr(input logic [2:0] idx, input logic [3:0] cyc,
                        input logic [3:0] mask, input logic [63:0] ex);
    cfg_we = 1'b1; cfg_idx = idx; cfg_cycle = cyc; cfg_mask = mask; cfg_expect = ex;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic clear_prog;
    for (int i = 0; i < 16; i++) prog[i] = '0;
  endtask

  task automatic go(input logic [3:0] num, input exp_t e);
    cfg_num = num;
    start   = 1'b1;
    tick;
    start      = 1'b0;
    start_edge = edge_no;
    sb.push_back(e);
  endtask

  // Drives probe values cycle by cycle until done (bounded). Optionally checks
  // busy at one cycle and injects ignored cfg_we/start pulses during the run.
  task automatic run(input int busy_cyc, input logic busy_exp, input logic proto);
    for (int c = 0; c < 40; c++) begin
      if (c == busy_cyc) check("busy_mid_run", busy, busy_exp);
      if (done) break;
      probe = prog[c % 16];
      if (proto) begin
        cfg_we     = (c == 2);
        cfg_idx    = 3'd3;
        cfg_cycle  = 4'd12;
        cfg_mask   = 4'b0001;
        cfg_expect = pk(16'd99, 0, 0, 0);
        start      = (c == 4);
        cfg_num    = 4'd1;
      end
      tick;
    end
    cfg_we = 1'b0;
    start  = 1'b0;
    probe  = '0;
    check("run_reached_done", done, 1'b1);
  endtask

  task automatic load_t1;
    cfg_wr(3'd0, 4'd3,  4'b0001, pk(16'd2,  0, 0, 0));
    cfg_wr(3'd1, 4'd7,  4'b0001, pk(16'd7,  0, 0, 0));
    cfg_wr(3'd2, 4'd10, 4'b0010, pk(0, 16'd5, 0, 0));
    cfg_wr(3'd3, 4'd14, 4'b0001, pk(16'd12, 0, 0, 0));
    clear_prog;
    prog[3]  = pk(16'd2,  0, 0, 0);
    prog[7]  = pk(16'd7,  0, 0, 0);
    prog[10] = pk(0, 16'd5, 0, 0);
    prog[14] = pk(16'd12, 0, 0, 0);
  endtask

  // Scoreboard monitor: compares a completed run whenever done rises.
  initial begin
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clock);
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: actual=1 expected=0");
        end else begin
          e = sb.pop_front();
          check({e.name, "_pass"},    pass,       e.pass);
          check({e.name, "_fail"},    fail,       e.fail);
          check({e.name, "_busy"},    busy,       1'b0);
          check({e.name, "_idx"},     fail_idx,   e.idx);
          check({e.name, "_chan"},    fail_chan,  e.chan);
          check({e.name, "_value"},   fail_value, e.val);
          check({e.name, "_chk"},     chk_count,  e.chk);
          check({e.name, "_err"},     err_count,  e.err);
          check({e.name, "_latency"}, edge_no - start_edge, e.lat);
        end
      end
      done_q = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; probe = '0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_cycle = '0; cfg_mask = '0; cfg_expect = '0; cfg_num = '0;
    clear_prog;
    tick;
    tick;
    reset = 1'b0;
    tick;
    check("reset_busy",  busy,      1'b0);
    check("reset_done",  done,      1'b0);
    check("reset_pass",  pass,      1'b0);
    check("reset_fail",  fail,      1'b0);
    check("reset_chan",  fail_chan, 4'h0);
    check("reset_chk",   chk_count, 4'h0);
    check("reset_err",   err_count, 8'h0);

    // T1: all entries match
    load_t1;
    go(4'd4, mk("t1", 1, 0, 0, 4'h0, 0, 4'd4, 8'd0, 15));
    run(-1, 1'b0, 1'b0);

    // T2: last entry mismatches (mary=11)
    prog[14] = pk(16'd11, 0, 0, 0);
    go(4'd4, mk("t2", 0, 1, 3'd3, 4'b0001, 16'd11, 4'd4, 8'd1, 15));
    run(-1, 1'b0, 1'b0);

    // T3: entries 1 and 3 mismatch
    prog[7]  = pk(16'd8,  0, 0, 0);
    prog[14] = pk(16'd13, 0, 0, 0);
`ifdef FRANKIE_MON_CONTINUE_EN
    go(4'd4, mk("t3", 0, 1, 3'd1, 4'b0001, 16'd8, 4'd4, 8'd2, 15));
    run(8, 1'b1, 1'b0);
`else
    go(4'd4, mk("t3", 0, 1, 3'd1, 4'b0001, 16'd8, 4'd2, 8'd1, 8));
    run(8, 1'b0, 1'b0);
`endif

    // T4a: second entry earlier than the first -> missed checkpoint
    cfg_wr(3'd0, 4'd9, 4'b0000, '0);
    cfg_wr(3'd1, 4'd6, 4'b0000, '0);
    go(4'd2, mk("t4_missed", 0, 1, 3'd1, 4'h0, 0, 4'd2, 8'd1, 11));
    run(-1, 1'b0, 1'b0);

    // T4b: only entry sits on the counter's last value -> timeout
    cfg_wr(3'd0, 4'd15, 4'b0001, '0);
    go(4'd1, mk("t4_timeout", 0, 1, 3'd0, 4'hF, 0, 4'd0, 8'd0, 16));
    run(-1, 1'b0, 1'b0);

    // T6: mask 0 with garbage expect, then sp-only compare
    cfg_wr(3'd0, 4'd2, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF);
    cfg_wr(3'd1, 4'd5, 4'b1000, pk(16'h1111, 16'h2222, 16'h3333, 16'h0000));
    clear_prog;
    prog[5] = pk(16'h1234, 16'h5678, 16'h9ABC, 16'h0000);
    go(4'd2, mk("t6_mask", 1, 0, 0, 4'h0, 0, 4'd2, 8'd0, 6));
    run(-1, 1'b0, 1'b0);

    // Zero-length run
    go(4'd0, mk("zero_len", 1, 0, 0, 4'h0, 0, 4'd0, 8'd0, 1));
    run(-1, 1'b0, 1'b0);

    // T5: cfg_we and start during RUN are ignored
    load_t1;
    go(4'd4, mk("t5_ignored", 1, 0, 0, 4'h0, 0, 4'd4, 8'd0, 15));
    run(-1, 1'b0, 1'b1);

    // T5: reset mid-run
    cfg_num = 4'd4;
    start   = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      probe = prog[c];
      tick;
    end
    check("pre_reset_busy", busy,      1'b1);
    check("pre_reset_chk",  chk_count, 4'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_busy", busy,      1'b0);
    check("midreset_done", done,      1'b0);
    check("midreset_chk",  chk_count, 4'd0);
    check("midreset_err",  err_count, 8'd0);
    @(negedge clock);
    reset = 1'b0;
    probe = '0;
    tick;

    // Table was cleared: entry 0 is cycle 0, mask 0 -> passes at once
    go(4'd1, mk("post_reset_table", 1, 0, 0, 4'h0, 0, 4'd1, 8'd0, 1));
    run(-1, 1'b0, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick;
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
